// File: rtl/programador_ciclos.sv
// rtl/programador_ciclos.sv - R-G-B dosing sequencer driving an external cycle timer.
// Define PROGRAMADOR_REDONDEO_EN to quantise intensities with rounding and saturation.
module programador_ciclos #(
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       start,
  input  logic [2:0] flags,
  output logic [4:0] ciclos_R,
  output logic [4:0] ciclos_G,
  output logic [4:0] ciclos_B,
  output logic       enter,
  output logic [2:0] motor,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, ARM, RUN_R, RUN_G, RUN_B, FAULT} estado_t;

  localparam logic [4:0] LIMITE = 5'(TIMEOUT - 1);

  estado_t    estado;
  logic [4:0] cnt;
  logic       flag_fase;

  function automatic logic [4:0] cuantiza(input logic [7:0] x);
`ifdef PROGRAMADOR_REDONDEO_EN
    logic [8:0] s;
    s = {1'b0, x} + 9'd8;
    if (s[8]) return 5'd15;
    else      return {1'b0, s[7:4]};
`else
    return 5'(x >> 4);
`endif
  endfunction

  // Only the flag belonging to the active phase is ever looked at.
  always_comb begin
    flag_fase = 1'b0;
    case (estado)
      RUN_R:   flag_fase = flags[2];
      RUN_G:   flag_fase = flags[1];
      RUN_B:   flag_fase = flags[0];
      default: flag_fase = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      cnt      <= 5'd0;
      ciclos_R <= 5'd0;
      ciclos_G <= 5'd0;
      ciclos_B <= 5'd0;
      enter    <= 1'b0;
      motor    <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      enter <= 1'b0;
      done  <= 1'b0;
      case (estado)
        IDLE: begin
          if (load) begin
            ciclos_R <= cuantiza(r_in);
            ciclos_G <= cuantiza(g_in);
            ciclos_B <= cuantiza(b_in);
          end
          if (start) begin
            estado <= ARM;
            enter  <= 1'b1;
            busy   <= 1'b1;
            cnt    <= 5'd0;
          end
        end
        ARM: begin
          estado <= RUN_R;
          motor  <= 3'b100;
          cnt    <= 5'd0;
        end
        RUN_R, RUN_G, RUN_B: begin
          // A flag arriving on the timeout cycle still advances the phase.
          if (flag_fase) begin
            cnt <= 5'd0;
            case (estado)
              RUN_R: begin
                estado <= RUN_G;
                motor  <= 3'b010;
              end
              RUN_G: begin
                estado <= RUN_B;
                motor  <= 3'b001;
              end
              default: begin
                estado <= IDLE;
                motor  <= 3'b000;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            endcase
          end else if (cnt == LIMITE) begin
            estado <= FAULT;
            motor  <= 3'b000;
            busy   <= 1'b0;
            err    <= 1'b1;
            cnt    <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FAULT: begin
          if (start) begin
            estado <= IDLE;
            err    <= 1'b0;
          end
        end
        default: begin
          estado <= IDLE;
          motor  <= 3'b000;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
